cmp_sequencer: RTL and testbench
================================

// Module: cmp_sequencer
// PURPOSE
//   Initiator that drives the registered compare unit in the ALU. It accepts one operand
//   pair per valid/ready request and issues the EQ, GT and LT compare functions
//   back-to-back. It captures each registered result one cycle after issue, decodes the
//   codes into relation flags, and returns one response through a valid/ready handshake.
//   It sits between the ALU control path and the compare unit.
// PARAMETERS
//   DATA_WIDTH  8  operand width and width of the compare unit result bus; must be >= 2
// PORTS
//   clk        in   1           rising-edge clock
//   rst        in   1           synchronous, active-high reset
//   req_valid  in   1           request operand pair is valid
//   req_ready  out  1           block can accept a request; high only in IDLE
//   req_a      in   DATA_WIDTH  operand A (unsigned)
//   req_b      in   DATA_WIDTH  operand B (unsigned)
//   res_valid  out  1           response is valid
//   res_ready  in   1           consumer accepts the response
//   res_eq     out  1           A == B
//   res_gt     out  1           A > B
//   res_lt     out  1           A < B
//   res_err    out  1           protocol or consistency fault seen during this request
//   cmp_in1    out  DATA_WIDTH  to compare unit in1 (registered)
//   cmp_in2    out  DATA_WIDTH  to compare unit in2 (registered)
//   cmp_fun    out  2           to compare unit function select (registered)
//   cmp_en     out  1           to compare unit enable (registered)
//   cmp_out    in   DATA_WIDTH  from compare unit result: 0 none, 1 eq, 2 gt, 3 lt
//   cmp_flag   in   1           from compare unit: result valid
// BEHAVIOUR
//   Reset values:
//   - All outputs and flags 0; state IDLE. req_ready is 1 once the block is in IDLE.
//   Compare unit contract:
//   - The unit registers its result, so a function driven during cycle t appears on
//     cmp_out/cmp_flag during cycle t+1.
//   - The compare unit has no reset. Its outputs are ignored outside the capture states.
//   State machine: IDLE -> S_EQ -> S_GT -> S_LT -> S_DRAIN -> S_RESP -> IDLE.
//   - IDLE: req_ready=1. On req_valid at the clock edge:
//     - load cmp_in1<=req_a and cmp_in2<=req_b;
//     - cmp_fun<=01, cmp_en<=1;
//     - clear eq/gt/lt/err; go to S_EQ.
//   - S_EQ: cmp_fun<=10; go to S_GT.
//   - S_GT: capture the EQ result (expected code 1); cmp_fun<=11; go to S_LT.
//   - S_LT: capture the GT result (expected code 2); cmp_en<=0, cmp_fun<=00; go to S_DRAIN.
//   - S_DRAIN: capture the LT result (expected code 3); res_valid<=1; go to S_RESP.
//   - S_RESP: res_* held stable while res_ready=0. On res_ready: res_valid<=0; go to IDLE.
//   Capture rule:
//   - cmp_out equal to the zero-extended expected code sets that relation flag.
//   - cmp_out==0 leaves the flag clear.
//   - Any other cmp_out value, or cmp_flag==0, sets err.
//   Consistency rule (evaluated on entry to S_RESP):
//   - err is also set if eq+gt+lt is not exactly one.
//   - The flags are still reported as captured.
//   Timing and throughput:
//   - res_valid rises 4 edges after the accepting edge.
//   - Minimum 6 cycles per request. req_ready is 0 from the accepting edge until return to IDLE.
//   - No request is accepted in S_RESP, even when res_ready=1 in the same cycle.
//   Other rules:
//   - req_a/req_b are sampled only at acceptance; later changes have no effect.
//   - cmp_in1/cmp_in2 hold their values after a request completes.
//   - rst in any state overrides everything: next cycle state=IDLE, cmp_en=0, res_valid=0, and any in-flight request is dropped.
// TESTING
//   - a=5, b=5 -> eq=1, gt=0, lt=0, err=0; res_valid 4 cycles after accept; cmp_fun sequence 01,10,11,00.
//   - a=200, b=3 -> gt=1 only, err=0.
//   - a=3, b=200 -> lt=1 only, err=0.
//     Then a=255, b=0 issued in the cycle after response handshake -> gt=1.
//   - a=7, b=9 with res_ready held 0 for 10 cycles -> res_* stable, req_ready=0 throughout.
//     After res_ready=1 -> IDLE next cycle.
//   - Bench compare-unit model forces cmp_flag=0 during S_GT for a=4, b=4 -> err=1, eq=0.
//     The next clean request -> err=0.
//   - rst pulsed for 1 cycle in S_GT -> next cycle cmp_en=0, req_ready=1, res_valid=0.
//     No response is ever produced for the dropped request.

Source files
------------

// File: rtl/cmp_sequencer.sv
// cmp_sequencer
//   Drives a registered compare unit through the EQ, GT and LT functions for one
//   operand pair, decodes the three registered result codes into relation flags and
//   hands a single response back to the requester.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   req_valid/req_ready  request handshake; req_a/req_b are unsigned operands
//   res_valid/res_ready  response handshake; res_eq/res_gt/res_lt relation flags,
//                        res_err protocol or consistency fault for this request
//   cmp_in1/cmp_in2      registered operands to the compare unit
//   cmp_fun/cmp_en       registered function select / enable to the compare unit
//   cmp_out/cmp_flag     registered result code and result-valid from the compare unit
//   state_dbg            current FSM state, for observation only
//
// Handshake semantics: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its payload stable while valid is high and ready is
// low; ready never depends combinationally on valid.

module cmp_sequencer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_eq,
    output logic                  res_gt,
    output logic                  res_lt,
    output logic                  res_err,
    output logic [DATA_WIDTH-1:0] cmp_in1,
    output logic [DATA_WIDTH-1:0] cmp_in2,
    output logic [1:0]            cmp_fun,
    output logic                  cmp_en,
    input  logic [DATA_WIDTH-1:0] cmp_out,
    input  logic                  cmp_flag,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        S_EQ    = 3'd1,
        S_GT    = 3'd2,
        S_LT    = 3'd3,
        S_DRAIN = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t                state_q, state_n;
    logic [DATA_WIDTH-1:0] in1_n, in2_n;
    logic [1:0]            fun_n;
    logic                  en_n;
    logic                  eq_n, gt_n, lt_n, err_n;
    logic                  rvalid_n;

    // Result decode for whichever function's result is on cmp_out this cycle.
    logic [1:0]            exp_code;
    logic                  cap_hit;
    logic                  cap_bad;

    assign req_ready = (state_q == IDLE);
    assign state_dbg = state_q;

    // The unit registers its result, so the code seen in S_GT belongs to the EQ
    // issue, S_LT to GT and S_DRAIN to LT.
    always_comb begin
        exp_code = 2'd0;
        case (state_q)
            S_GT:    exp_code = 2'd1;
            S_LT:    exp_code = 2'd2;
            S_DRAIN: exp_code = 2'd3;
            default: exp_code = 2'd0;
        endcase
        cap_hit = cmp_flag && (cmp_out == DATA_WIDTH'(exp_code));
        cap_bad = !cmp_flag ||
                  ((cmp_out != '0) && (cmp_out != DATA_WIDTH'(exp_code)));
    end

    always_comb begin
        state_n  = state_q;
        in1_n    = cmp_in1;
        in2_n    = cmp_in2;
        fun_n    = cmp_fun;
        en_n     = cmp_en;
        eq_n     = res_eq;
        gt_n     = res_gt;
        lt_n     = res_lt;
        err_n    = res_err;
        rvalid_n = res_valid;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    in1_n   = req_a;
                    in2_n   = req_b;
                    fun_n   = 2'b01;
                    en_n    = 1'b1;
                    eq_n    = 1'b0;
                    gt_n    = 1'b0;
                    lt_n    = 1'b0;
                    err_n   = 1'b0;
                    state_n = S_EQ;
                end
            end
            S_EQ: begin
                fun_n   = 2'b10;
                state_n = S_GT;
            end
            S_GT: begin
                eq_n    = cap_hit;
                err_n   = res_err | cap_bad;
                fun_n   = 2'b11;
                state_n = S_LT;
            end
            S_LT: begin
                gt_n    = cap_hit;
                err_n   = res_err | cap_bad;
                en_n    = 1'b0;
                fun_n   = 2'b00;
                state_n = S_DRAIN;
            end
            S_DRAIN: begin
                lt_n     = cap_hit;
                // Exactly one relation must hold; flags are still reported as seen.
                err_n    = res_err | cap_bad |
                           (({1'b0, res_eq} + {1'b0, res_gt} + {1'b0, cap_hit}) != 2'd1);
                rvalid_n = 1'b1;
                state_n  = S_RESP;
            end
            S_RESP: begin
                // No acceptance here: a new request waits for IDLE.
                if (res_ready) begin
                    rvalid_n = 1'b0;
                    state_n  = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cmp_in1   <= '0;
            cmp_in2   <= '0;
            cmp_fun   <= 2'b00;
            cmp_en    <= 1'b0;
            res_eq    <= 1'b0;
            res_gt    <= 1'b0;
            res_lt    <= 1'b0;
            res_err   <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            state_q   <= state_n;
            cmp_in1   <= in1_n;
            cmp_in2   <= in2_n;
            cmp_fun   <= fun_n;
            cmp_en    <= en_n;
            res_eq    <= eq_n;
            res_gt    <= gt_n;
            res_lt    <= lt_n;
            res_err   <= err_n;
            res_valid <= rvalid_n;
        end
    end

endmodule

// File: tb/tb_cmp_sequencer.sv
// tb_cmp_sequencer
//   Directed and randomized requests against cmp_sequencer, with a registered
//   compare-unit model that can inject faults, and a flag reference computed
//   directly from the operands.

module tb_cmp_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a, req_b;
    logic         res_valid;
    logic         res_ready;
    logic         res_eq, res_gt, res_lt, res_err;
    logic [W-1:0] cmp_in1, cmp_in2;
    logic [1:0]   cmp_fun;
    logic         cmp_en;
    logic [W-1:0] cmp_out;
    logic         cmp_flag;
    logic [2:0]   state_dbg;

    int checks   = 0;
    int failures = 0;

    // 0 clean, 1 EQ result flag dropped, 2 all codes read 0, 3 GT code corrupted
    int inj_mode = 0;

    // Scoreboard entries are {eq, gt, lt, err}.
    logic [3:0] exp_q[$];

    cmp_sequencer #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_eq    (res_eq),
        .res_gt    (res_gt),
        .res_lt    (res_lt),
        .res_err   (res_err),
        .cmp_in1   (cmp_in1),
        .cmp_in2   (cmp_in2),
        .cmp_fun   (cmp_fun),
        .cmp_en    (cmp_en),
        .cmp_out   (cmp_out),
        .cmp_flag  (cmp_flag),
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Registered compare unit without reset.
    initial begin
        cmp_out  = '0;
        cmp_flag = 1'b0;
    end

    always @(posedge clk) begin
        cmp_flag <= cmp_en;
        case (cmp_fun)
            2'b01:   cmp_out <= (cmp_in1 == cmp_in2) ? W'(1) : W'(0);
            2'b10:   cmp_out <= (cmp_in1 >  cmp_in2) ? W'(2) : W'(0);
            2'b11:   cmp_out <= (cmp_in1 <  cmp_in2) ? W'(3) : W'(0);
            default: cmp_out <= W'(0);
        endcase
        if (inj_mode == 1 && cmp_fun == 2'b01) cmp_flag <= 1'b0;
        if (inj_mode == 2) cmp_out <= W'(0);
        if (inj_mode == 3 && cmp_fun == 2'b10) cmp_out <= W'(5);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: relations from the operands, then knock out whatever slot the
    // injected fault spoils; any fault means err.
    function automatic logic [3:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input int mode);
        logic e, g, l;
        e = (a == b) && mode != 1 && mode != 2;
        g = (a >  b) && mode != 2 && mode != 3;
        l = (a <  b) && mode != 2;
        return {e, g, l, (mode != 0)};
    endfunction

    // Driver: one full request/response. Called at posedge+1 with the DUT in IDLE.
    task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input int mode,
                          input int hold, input bit check_fun, input bit early_valid);
        logic [1:0] fun_exp[4];
        logic [3:0] held;
        logic [3:0] e;
        int n;
        fun_exp[0] = 2'b01;
        fun_exp[1] = 2'b10;
        fun_exp[2] = 2'b11;
        fun_exp[3] = 2'b00;

        inj_mode  = mode;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        exp_q.push_back(ref_flags(a, b, mode));
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a = W'($urandom);
        req_b = W'($urandom);

        n = 0;
        while (!res_valid && n < 12) begin
            if (check_fun && n < 4) chk("cmp_fun_seq", 32'(cmp_fun), 32'(fun_exp[n]));
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        chk("resp_latency", 32'(n), 32'd4);
        if (!res_valid) begin
            void'(exp_q.pop_front());
            return;
        end

        held = {res_eq, res_gt, res_lt, res_err};
        res_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_stable", 32'({res_valid, res_eq, res_gt, res_lt, res_err}),
                32'({1'b1, held}));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end

        res_ready = 1'b1;
        if (early_valid) begin
            req_valid = 1'b1;
            req_a = W'($urandom);
        end
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("resp_flags", 32'({res_eq, res_gt, res_lt, res_err}), 32'(e));
        end
        @(posedge clk); #1;
        res_ready = 1'b0;
        req_valid = 1'b0;
        chk("resp_valid_drop", 32'(res_valid), 32'd0);
        chk("back_to_idle", 32'(req_ready), 32'd1);
        chk("cmp_en_off", 32'(cmp_en), 32'd0);
        chk("cmp_in1_hold", 32'(cmp_in1), 32'(a));
        chk("cmp_in2_hold", 32'(cmp_in2), 32'(b));
    endtask

    // Reset pulsed while the request sits in S_GT; it must vanish.
    task automatic reset_mid_request();
        inj_mode  = 0;
        req_a     = W'(6);
        req_b     = W'(6);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_cmp_en", 32'(cmp_en), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("rst_no_resp", 32'(res_valid), 32'd0);
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int           rmode;

        // Reset
        rst       = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_outputs",
            32'({res_valid, res_eq, res_gt, res_lt, res_err, cmp_en, cmp_fun}), 32'd0);
        chk("reset_cmp_in", 32'({cmp_in1, cmp_in2}), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);

        // Directed
        do_req(W'(5),   W'(5),   0, 0,  1'b1, 1'b0);
        do_req(W'(200), W'(3),   0, 0,  1'b0, 1'b0);
        do_req(W'(3),   W'(200), 0, 0,  1'b0, 1'b1);
        do_req(W'(255), W'(0),   0, 0,  1'b0, 1'b0);
        do_req(W'(7),   W'(9),   0, 10, 1'b0, 1'b1);
        do_req(W'(4),   W'(4),   1, 0,  1'b0, 1'b0);
        do_req(W'(10),  W'(20),  0, 1,  1'b0, 1'b0);
        do_req(W'(9),   W'(9),   2, 0,  1'b0, 1'b0);
        do_req(W'(50),  W'(1),   3, 2,  1'b0, 1'b0);
        do_req(W'(0),   W'(255), 0, 0,  1'b0, 1'b0);
        reset_mid_request();
        do_req(W'(1),   W'(2),   0, 0,  1'b0, 1'b0);

        // Randomized
        for (int k = 0; k < 40; k++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            rmode = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_req(ra, rb, rmode, int'($urandom_range(0, 3)), 1'b0,
                   1'($urandom_range(0, 1)));
        end

        // Report
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
